// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle ALU ops plus a serial 1-bit-per-cycle shifter,
// with a valid/ready handshake on both the operation and the registered result.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam logic [3:0] OP_SLT  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {K_PASS, K_SLL, K_SRL, K_SRA} kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   shamt;
    logic             is_shift;

    assign shamt    = operand_b[SHW-1:0];
    assign is_shift = (ALU_opcode == OP_SLL) || (ALU_opcode == OP_SRL) || (ALU_opcode == OP_SRA);

    always_comb begin
        alu_res = '0;
        case (ALU_opcode)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shifted = acc_q;
        case (kind_q)
            K_SLL:   shifted = {acc_q[WIDTH-2:0], 1'b0};
            K_SRL:   shifted = {1'b0, acc_q[WIDTH-1:1]};
            K_SRA:   shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    // Single-cycle results ride through SHIFT as a one-step pass so every
                    // op lands max(1, shamt) edges after accept.
                    if (is_shift && shamt != '0) begin
                        acc_d  = operand_a;
                        cnt_d  = shamt;
                        kind_d = (ALU_opcode == OP_SLL) ? K_SLL :
                                 (ALU_opcode == OP_SRL) ? K_SRL : K_SRA;
                    end else begin
                        acc_d  = is_shift ? operand_a : alu_res;
                        cnt_d  = SHW'(1);
                        kind_d = K_PASS;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d    = shifted;
                    zero_d      = (shifted == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= K_PASS;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected result and latency are queued at accept
// and compared when out_valid rises.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_opcode(ALU_opcode), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0011: return a & b;
            4'b0100: return a | b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return a ^ b;
            4'b0000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1010: return $signed(a) >>> b[4:0];
            4'b1011: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'b0101 || op == 4'b0110 || op == 4'b1010) && b[4:0] != 5'd0)
            return int'(b[4:0]);
        return 1;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        check("in_ready_idle", in_ready, 1);
        ALU_opcode = op; operand_a = a; operand_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model(op, a, b));
        lat_q.push_back(model_lat(op, b));
        // Scramble inputs after accept; the unit must have captured them.
        in_valid = 1'b0; operand_a = ~a; operand_b = b ^ 32'h5; ALU_opcode = op ^ 4'h3;
        check("in_ready_busy", in_ready, 0);
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        logic [31:0] e;
        int l;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(l));
        check({tag, "_result"}, result, e);
        check({tag, "_zero"}, zero, (e == 32'd0));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_out_valid", out_valid, 0);
        check("consume_in_ready", in_ready, 1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_result(tag);
        consume();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALU_opcode = 4'h0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("sub",      4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("slt",      4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("sltu",     4'b1011, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("sra4",     4'b1010, 32'h8000_0000, 32'hFFFF_FFE4);
        do_op("srl4",     4'b0110, 32'h8000_0000, 32'hFFFF_FFE4);
        do_op("sll31",    4'b0101, 32'h0000_0001, 32'h0000_001F);
        do_op("sll0",     4'b0101, 32'h1234_5678, 32'h0000_0020);
        do_op("bad_op",   4'b1101, 32'h1234_5678, 32'h0000_0001);

        // Backpressure: result held while out_ready stays low; in_valid pulses ignored.
        issue(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        wait_result("and");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ALU_opcode = 4'b0001; operand_a = 32'd7; operand_b = 32'd9;
            @(posedge clk); #1;
            check("bp_result", result, 32'h00F0_00F0);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume();
        @(posedge clk); #1;
        check("bp_no_ghost", out_valid, 0);

        // Reset in the middle of a 20-step shift.
        issue(4'b0101, 32'h0000_0001, 32'd20);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 1);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op("add_after_rst", 4'b0001, 32'd100, 32'd23);

        for (int i = 0; i < 10; i++) begin
            do_op("rand", 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
